// File: rtl/mpmc11_resv_table_if.sv
// Request and table-state bundle between the mpmc11 controller and its reservation table.
interface mpmc11_resv_table_if #(
    parameter int unsigned NAR = 4
);
    logic                       lr;
    logic [3:0]                 lr_ch;
    logic [31:0]                lr_adr;
    logic                       we;
    logic                       cr;
    logic [3:0]                 wch;
    logic [31:0]                adr;
    logic [NAR-1:0][3:0]        resv_ch;
    logic [NAR-1:0][31:0]       resv_adr;
    logic [NAR-1:0]             resv_vld;
    logic [$clog2(NAR+1)-1:0]   resv_cnt;
    logic                       evict;

    modport master (
        output lr, lr_ch, lr_adr, we, cr, wch, adr,
        input  resv_ch, resv_adr, resv_vld, resv_cnt, evict
    );

    modport slave (
        input  lr, lr_ch, lr_adr, we, cr, wch, adr,
        output resv_ch, resv_adr, resv_vld, resv_cnt, evict
    );
endinterface

// File: rtl/mpmc11_resv_table.sv
// LR reservation table: one line-granular reservation per channel, cleared by
// conflicting writes and by the owning channel's store-conditional.
module mpmc11_resv_table #(
    parameter int unsigned NAR  = 4,
    parameter logic [3:0]  NOCH = 4'hF
) (
    input logic                clk,
    input logic                rst,
    mpmc11_resv_table_if.slave bus
);
    localparam int unsigned IW = (NAR > 1) ? $clog2(NAR) : 1;
    localparam int unsigned CW = $clog2(NAR + 1);

    logic [NAR-1:0][3:0]  r_ch;
    logic [NAR-1:0][31:0] r_adr;
    logic [NAR-1:0]       r_vld;
    logic [CW-1:0]        r_cnt;
    logic                 r_evict;
    logic [IW-1:0]        r_vic;

    logic [NAR-1:0][3:0]  w_ch;
    logic [NAR-1:0][31:0] w_adr;
    logic [NAR-1:0]       w_vld;
    logic [CW-1:0]        w_cnt;
    logic                 w_evict;
    logic [IW-1:0]        w_vic;
    logic                 w_lr_ok;
    logic                 w_hit;
    logic [IW-1:0]        w_hit_idx;
    logic                 w_free;
    logic [IW-1:0]        w_free_idx;
    logic [IW-1:0]        w_sel;

    // Clears are applied to the working copy first so LR placement sees the post-clear table.
    always_comb begin
        w_ch       = r_ch;
        w_adr      = r_adr;
        w_vld      = r_vld;
        w_cnt      = '0;
        w_evict    = 1'b0;
        w_vic      = r_vic;
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_sel      = '0;
        w_lr_ok    = bus.lr && (bus.lr_ch != NOCH);

        for (int unsigned i = 0; i < NAR; i++) begin
            if (bus.we && ((r_vld[i] && (r_adr[i][31:5] == bus.adr[31:5])) ||
                           (bus.cr && (r_ch[i] == bus.wch)))) begin
                w_ch[i]  = NOCH;
                w_adr[i] = '0;
                w_vld[i] = 1'b0;
            end
        end

        for (int unsigned i = 0; i < NAR; i++) begin
            if (!w_hit && (w_ch[i] == bus.lr_ch)) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
            if (!w_free && !w_vld[i]) begin
                w_free     = 1'b1;
                w_free_idx = IW'(i);
            end
        end

        if (w_lr_ok) begin
            if (w_hit) begin
                w_sel = w_hit_idx;
            end else if (w_free) begin
                w_sel = w_free_idx;
            end else begin
                w_sel   = r_vic;
                w_evict = 1'b1;
                w_vic   = (r_vic == IW'(NAR - 1)) ? '0 : r_vic + IW'(1);
            end
            w_ch[w_sel]  = bus.lr_ch;
            w_adr[w_sel] = {bus.lr_adr[31:5], 5'b0};
            w_vld[w_sel] = 1'b1;
        end

        for (int unsigned i = 0; i < NAR; i++) begin
            w_cnt = w_cnt + CW'(w_vld[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch    <= {NAR{NOCH}};
            r_adr   <= '0;
            r_vld   <= '0;
            r_cnt   <= '0;
            r_evict <= 1'b0;
            r_vic   <= '0;
        end else begin
            r_ch    <= w_ch;
            r_adr   <= w_adr;
            r_vld   <= w_vld;
            r_cnt   <= w_cnt;
            r_evict <= w_evict;
            r_vic   <= w_vic;
        end
    end

    assign bus.resv_ch  = r_ch;
    assign bus.resv_adr = r_adr;
    assign bus.resv_vld = r_vld;
    assign bus.resv_cnt = r_cnt;
    assign bus.evict    = r_evict;
endmodule

// File: tb/tb_mpmc11_resv_table.sv
// Directed bench for mpmc11_resv_table: hand-written expected tables queued per step.
module tb_mpmc11_resv_table;
    localparam int unsigned NAR = 4;
    localparam int unsigned CW  = $clog2(NAR + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mpmc11_resv_table_if #(.NAR(NAR)) bus ();

    mpmc11_resv_table #(.NAR(NAR), .NOCH(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [NAR-1:0][3:0]  ch;
        logic [NAR-1:0][31:0] adr;
        logic [NAR-1:0]       vld;
        logic [CW-1:0]        cnt;
        logic                 ev;
    } snap_t;

    snap_t sb[$];
    snap_t e;
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input string step);
        snap_t x;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s scoreboard: observed empty queue expected entry", step);
        end else begin
            x = sb.pop_front();
            chk({step, " resv_vld"}, 128'(bus.resv_vld), 128'(x.vld));
            chk({step, " resv_ch"},  128'(bus.resv_ch),  128'(x.ch));
            chk({step, " resv_adr"}, 128'(bus.resv_adr), 128'(x.adr));
            chk({step, " resv_cnt"}, 128'(bus.resv_cnt), 128'(x.cnt));
            chk({step, " evict"},    128'(bus.evict),    128'(x.ev));
        end
    endtask

    task automatic put(input int unsigned i, input logic [3:0] ch, input logic [31:0] a);
        e.ch[i]  = ch;
        e.adr[i] = a;
        e.vld[i] = 1'b1;
    endtask

    task automatic clr(input int unsigned i);
        e.ch[i]  = 4'hF;
        e.adr[i] = '0;
        e.vld[i] = 1'b0;
    endtask

    task automatic clr_all();
        for (int unsigned i = 0; i < NAR; i++) clr(i);
    endtask

    task automatic exp_push(input logic ev);
        e.ev  = ev;
        e.cnt = CW'($countones(e.vld));
        sb.push_back(e);
    endtask

    task automatic cyc(input string step,
                       input logic lr, input logic [3:0] lch, input logic [31:0] la,
                       input logic we, input logic cr, input logic [3:0] wc, input logic [31:0] wa);
        bus.lr     = lr;
        bus.lr_ch  = lch;
        bus.lr_adr = la;
        bus.we     = we;
        bus.cr     = cr;
        bus.wch    = wc;
        bus.adr    = wa;
        @(posedge clk);
        #1;
        bus.lr = 1'b0;
        bus.we = 1'b0;
        bus.cr = 1'b0;
        compare_out(step);
    endtask

    initial begin
        rst        = 1'b1;
        bus.lr     = 1'b0;
        bus.lr_ch  = '0;
        bus.lr_adr = '0;
        bus.we     = 1'b0;
        bus.cr     = 1'b0;
        bus.wch    = '0;
        bus.adr    = '0;
        repeat (2) @(posedge clk);
        #1;
        clr_all();
        exp_push(1'b0);
        compare_out("reset");
        @(negedge clk);
        rst = 1'b0;

        // Low address bits are dropped on store
        put(0, 4'd1, 32'h1000_0040); exp_push(1'b0);
        cyc("lr1", 1, 4'd1, 32'h1000_005F, 0, 0, 4'd0, 32'h0);

        put(0, 4'd1, 32'h2000_0000); exp_push(1'b0);
        cyc("lr1_move", 1, 4'd1, 32'h2000_0000, 0, 0, 4'd0, 32'h0);

        put(1, 4'd2, 32'h3000_0020); exp_push(1'b0);
        cyc("lr2", 1, 4'd2, 32'h3000_0020, 0, 0, 4'd0, 32'h0);

        clr(1); exp_push(1'b0);
        cyc("snoop", 0, 4'd0, 32'h0, 1, 0, 4'd5, 32'h3000_003C);

        put(1, 4'd3, 32'h4000_0000); exp_push(1'b0);
        cyc("lr3", 1, 4'd3, 32'h4000_0000, 0, 0, 4'd0, 32'h0);

        clr(1); exp_push(1'b0);
        cyc("sc3_other", 0, 4'd0, 32'h0, 1, 1, 4'd3, 32'h5000_0000);

        clr(0); exp_push(1'b0);
        cyc("sc1_own", 0, 4'd0, 32'h0, 1, 1, 4'd1, 32'h2000_0000);

        for (int unsigned c = 0; c < 4; c++) begin
            put(c, 4'(c), 32'h0000_1000 + 32'(c) * 32'h100);
            exp_push(1'b0);
            cyc("fill", 1, 4'(c), 32'h0000_1000 + 32'(c) * 32'h100, 0, 0, 4'd0, 32'h0);
        end

        put(0, 4'd4, 32'h0000_2000); exp_push(1'b1);
        cyc("evict0", 1, 4'd4, 32'h0000_2000, 0, 0, 4'd0, 32'h0);

        put(1, 4'd5, 32'h0000_2100); exp_push(1'b1);
        cyc("evict1", 1, 4'd5, 32'h0000_2100, 0, 0, 4'd0, 32'h0);

        exp_push(1'b0);
        cyc("evict_drop", 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0);

        put(2, 4'd6, 32'h0000_3000); exp_push(1'b0);
        cyc("clr_reuse", 1, 4'd6, 32'h0000_3000, 1, 0, 4'd2, 32'h0000_1200);

        put(2, 4'd6, 32'h0000_3100); exp_push(1'b0);
        cyc("full_hit", 1, 4'd6, 32'h0000_3100, 0, 0, 4'd0, 32'h0);

        put(0, 4'd7, 32'h0000_2000); exp_push(1'b0);
        cyc("lr_same_line", 1, 4'd7, 32'h0000_2000, 1, 0, 4'd9, 32'h0000_2000);

        exp_push(1'b0);
        cyc("lr_noch", 1, 4'hF, 32'h0000_5000, 0, 0, 4'd0, 32'h0);

        put(2, 4'd8, 32'h0000_4000); exp_push(1'b1);
        cyc("evict2", 1, 4'd8, 32'h0000_4000, 0, 0, 4'd0, 32'h0);

        #2;
        rst = 1'b1;
        #1;
        clr_all();
        exp_push(1'b0);
        compare_out("async_rst");

        bus.lr     = 1'b1;
        bus.lr_ch  = 4'd1;
        bus.lr_adr = 32'h1000_0040;
        @(posedge clk);
        #1;
        bus.lr = 1'b0;
        exp_push(1'b0);
        compare_out("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        put(0, 4'd1, 32'h1000_0040); exp_push(1'b0);
        cyc("post_rst_lr", 1, 4'd1, 32'h1000_0040, 0, 0, 4'd0, 32'h0);
        for (int unsigned c = 1; c < 4; c++) begin
            put(c, 4'(c + 1), 32'h0000_6000 + 32'(c) * 32'h20);
            exp_push(1'b0);
            cyc("refill", 1, 4'(c + 1), 32'h0000_6000 + 32'(c) * 32'h20, 0, 0, 4'd0, 32'h0);
        end
        // Victim pointer must restart at entry 0 after reset
        put(0, 4'd5, 32'h0000_7000); exp_push(1'b1);
        cyc("vic_reset", 1, 4'd5, 32'h0000_7000, 0, 0, 4'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mpmc11_resv_table.md
# mpmc11_resv_table

Reservation table for the mpmc11 multi-port memory controller. Records load-reserved (LR) reservations per channel at 32-byte line granularity, and invalidates them on conflicting writes and on store-conditional completion. Its registered `resv_ch`/`resv_adr` arrays drive the store-conditional reservation-status bit logic, which checks them during the controller's IDLE-state write acceptance.

## Interface
Parameters:
- `NAR`, `mpmc11_pkg::NAR` (4): number of reservation entries, 2..16.
- `NOCH`, 4'hF: channel code stored in empty entries; never issued by a requester.

Ports:
- `clk`  in  1  controller clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `lr`  in  1  one-cycle strobe: place a reservation.
- `lr_ch`  in  4  channel issuing the LR.
- `lr_adr`  in  32  LR byte address; bits [31:5] are used.
- `we`  in  1  one-cycle strobe: a write is being committed.
- `cr`  in  1  qualifies `we` as a store-conditional.
- `wch`  in  4  writing channel.
- `adr`  in  32  write byte address; bits [31:5] are used.
- `resv_ch`  out  4 x NAR  channel field per entry.
- `resv_adr`  out  32 x NAR  address per entry; bits [4:0] are always stored as 0.
- `resv_vld`  out  NAR  entry valid.
- `resv_cnt`  out  $clog2(NAR+1)  number of valid entries.
- `evict`  out  1  one-cycle pulse: a valid reservation was displaced by replacement.

## Operation
- Line match: the address bits [31:5] are equal.
- An entry is empty when `resv_vld`=0. An empty entry always holds `resv_ch`=NOCH and `resv_adr`=0. This makes an empty entry never match in the downstream check, which does not look at valid bits.
- Write snoop: on `we`, every valid entry whose line matches `adr` is cleared, for any channel. This includes the writer's own entry, so a successful store-conditional consumes its reservation.
- Store-conditional: on `we`&`cr`, every entry with `resv_ch`==`wch` is also cleared, whatever its address. A channel's reservation is consumed by its store-conditional whether that store-conditional passes or fails.
- LR placement on `lr`, with at most one reservation per channel. Select the first rule that applies:
  - an entry with `resv_ch`==`lr_ch` exists: overwrite it with the new line;
  - otherwise, use the lowest-index empty entry;
  - otherwise, use entry `vic`, pulse `evict`, then set `vic`=(`vic`+1) mod NAR.
- `vic` is an internal round-robin pointer of $clog2(NAR) bits. Reset value is 0. It advances only on an eviction.
- `lr` and `we` in the same cycle: write clears are applied first, then LR placement runs on the post-clear table. Free-entry selection therefore sees the entries just cleared. An LR to the same line as a simultaneous write still gets its reservation.
- `resv_cnt` is the popcount of next-state `resv_vld`, registered.

## Timing
- Reset values: all `resv_vld`=0; all `resv_ch`=NOCH; all `resv_adr`=0; `resv_cnt`=0; `evict`=0; `vic`=0.
- Single registered stage. A strobe sampled at edge N is visible on the outputs after edge N.
- The downstream reservation-bit evaluation of a write sampled at edge N uses the table state from before edge N. The clear caused by that write never hides its own reservation.
- `evict` is high for exactly the one cycle after the LR that caused the eviction.
- No backpressure: the block accepts one `lr` and one `we` every cycle.
- `rst` asserted mid-operation empties the table immediately (asynchronously). Strobes present while `rst` is high are ignored.
- Channel code NOCH on `lr_ch` is illegal. On an illegal request, the behaviour is to ignore the LR, with no state change.

## Test plan
- Reset, then LR ch1 @0x1000_0040 -> next cycle: entry0 `resv_vld`=1, `resv_ch`=1, `resv_adr`=0x1000_0040; `resv_cnt`=1; all other entries hold NOCH/0.
- LR ch1 @0x1000_0040, then LR ch1 @0x2000_0000 -> still one entry, now 0x2000_0000; `resv_cnt`=1; `evict`=0.
- LR ch2 @0x3000_0020, then `we` ch5 `cr`=0 @0x3000_003C (same line) -> entry cleared; `resv_cnt`=0.
- LR ch3 @0x4000_0000, then `we`&`cr` ch3 @0x5000_0000 (different line) -> ch3 entry cleared.
- With NAR=4, LRs from ch0..ch3, then LR ch4 -> entry0 takes ch4 and `evict` pulses for 1 cycle; then LR ch5 -> entry1 replaced and `evict` pulses.
- Table full; same cycle: `we` ch0 @ch0's line and LR ch6 -> ch0's slot is reused, `evict`=0, `resv_cnt`=4.
- Assert `rst` mid-sequence -> all outputs return to reset values immediately; LR ch1 then lands in entry0.
